// File: rtl/spi_txn_scheduler.sv
// Request FIFO plus one-frame-at-a-time scheduler for the master side of SPI_Protocol.
// Define SPI_SCHED_STATS_EN to add the saturating xfer_count output.
module spi_txn_scheduler #(
    parameter int DEPTH      = 4,
    parameter int BITS       = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [BITS-1:0]         req_data,
    input  logic [1:0]              req_addr,
    input  logic                    req_cpol,
    input  logic                    req_cpha,
    output logic                    spi_start,
    output logic                    spi_load,
    output logic [BITS-1:0]         spi_data_in_master,
    output logic [1:0]              spi_address,
    output logic                    spi_cpol,
    output logic                    spi_cpha,
    input  logic [BITS-1:0]         spi_data_out_master,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BITS-1:0]         rsp_data,
    output logic [1:0]              rsp_addr,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
`ifdef SPI_SCHED_STATS_EN
    ,
    output logic [15:0]             xfer_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = BITS + 4;
    localparam int NW = $clog2(2 * BITS + 2);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [NW-1:0] FRAME_M01 = NW'(2 * BITS);
    localparam logic [NW-1:0] FRAME_M23 = NW'(2 * BITS + 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            req_ready_q;
    logic            do_push;
    logic            do_pop;

    state_t          state_q;
    logic [NW-1:0]   frame_q;
    logic [GW-1:0]   gap_q;
    logic            spi_start_q;
    logic            spi_load_q;
    logic [BITS-1:0] spi_data_q;
    logic [1:0]      spi_addr_q;
    logic            spi_cpol_q;
    logic            spi_cpha_q;
    logic            rsp_valid_q;
    logic [BITS-1:0] rsp_data_q;
    logic [1:0]      rsp_addr_q;
    logic            busy_q;

    // A new frame may only be popped while no response is waiting (backpressure).
    always_comb begin
        do_push = req_valid && req_ready_q;
        do_pop  = (state_q == S_IDLE) && (count_q != '0) && !rsp_valid_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Request FIFO; ready is registered from the next occupancy so there is no bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {req_cpha, req_cpol, req_addr, req_data};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q     <= count_d;
            req_ready_q <= (count_d != FULL);
        end
    end

    // Frame sequencer; the spi_* registers double as the active-request holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            gap_q       <= '0;
            spi_start_q <= 1'b0;
            spi_load_q  <= 1'b0;
            spi_data_q  <= '0;
            spi_addr_q  <= 2'd0;
            spi_cpol_q  <= 1'b0;
            spi_cpha_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= 2'd0;
            busy_q      <= 1'b0;
        end else begin
            spi_start_q <= 1'b0;
            spi_load_q  <= 1'b0;
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (do_pop) begin
                        {spi_cpha_q, spi_cpol_q, spi_addr_q, spi_data_q} <= mem_q[rd_ptr_q];
                        spi_start_q <= 1'b1;
                        spi_load_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    // Modes 2/3 spend one extra cycle on the skipped leading edge.
                    frame_q <= spi_cpol_q ? FRAME_M23 : FRAME_M01;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    frame_q <= frame_q - NW'(1);
                    if (frame_q == NW'(2)) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    rsp_data_q  <= spi_data_out_master;
                    rsp_addr_q  <= spi_addr_q;
                    rsp_valid_q <= 1'b1;
                    gap_q       <= GW'(GAP_CYCLES);
                    state_q     <= S_GAP;
                end
                S_GAP: begin
                    if (gap_q == GW'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_SCHED_STATS_EN
    logic [15:0] xfer_q;

    // Completed-transfer counter, saturating at all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_q <= 16'd0;
        end else if ((state_q == S_CAPTURE) && (xfer_q != 16'hFFFF)) begin
            xfer_q <= xfer_q + 16'd1;
        end
    end

    assign xfer_count = xfer_q;
`else
    // Statistics disabled: no transfer counter in this build.
`endif

    assign req_ready          = req_ready_q;
    assign fifo_count         = count_q;
    assign spi_start          = spi_start_q;
    assign spi_load           = spi_load_q;
    assign spi_data_in_master = spi_data_q;
    assign spi_address        = spi_addr_q;
    assign spi_cpol           = spi_cpol_q;
    assign spi_cpha           = spi_cpha_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_data           = rsp_data_q;
    assign rsp_addr           = rsp_addr_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Self-checking bench for spi_txn_scheduler: vector table, hand sequences and random traffic
// against a queue/formula reference model with a simple SPI slave responder.
`timescale 1ns/1ps
module tb_spi_txn_scheduler;
    localparam int BITS   = 8;
    localparam int DEPTH  = 4;
    localparam int GAP    = 2;
    localparam int PERIOD = 2 + 2 * BITS + GAP;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic [1:0] req_addr = 2'd0;
    logic       req_cpol = 1'b0;
    logic       req_cpha = 1'b0;
    logic       spi_start;
    logic       spi_load;
    logic [7:0] spi_data_in_master;
    logic [1:0] spi_address;
    logic       spi_cpol;
    logic       spi_cpha;
    logic [7:0] spi_data_out_master = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [1:0] rsp_addr;
    logic       busy;
    logic [2:0] fifo_count;
`ifdef SPI_SCHED_STATS_EN
    logic [15:0] xfer_count;
`endif

    spi_txn_scheduler #(.DEPTH(DEPTH), .BITS(BITS), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_addr(req_addr), .req_cpol(req_cpol), .req_cpha(req_cpha),
        .spi_start(spi_start), .spi_load(spi_load),
        .spi_data_in_master(spi_data_in_master), .spi_address(spi_address),
        .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
        .spi_data_out_master(spi_data_out_master),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .busy(busy), .fifo_count(fifo_count)
`ifdef SPI_SCHED_STATS_EN
        , .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [1:0] addr;
        logic       cpol;
        logic       cpha;
    } req_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] addr;
        logic       cpol;
        logic       cpha;
        logic [7:0] exp_rsp;
        int         exp_lat;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    req_t req_log [256];
    int   pushes = 0;
    int   acc_cyc = 0;
    bit   done_r = 1'b0;

    int         starts = 0;
    int         rsp_seen = 0;
    int         start_cyc = 0;
    int         last_lat = 0;
    logic [7:0] last_rsp_data = 8'h00;
    logic [1:0] last_rsp_addr = 2'd0;
    int         start_log [256];
    req_t       cur;
    bit         have_cur = 1'b0;
    bit         prev_start = 1'b0;
    bit         prev_rsp = 1'b0;
    int         slv_cnt = 0;
    int         slv_frame = 0;
    bit         slv_active = 1'b0;
    logic [7:0] slv_val = 8'h00;

    function automatic logic [7:0] slave_f(input logic [7:0] d, input logic [1:0] a);
        return d ^ 8'h7D ^ {6'b000000, a};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_spi_start"}, spi_start, 0);
        chk({p, "_spi_load"}, spi_load, 0);
        chk({p, "_spi_data"}, spi_data_in_master, 0);
        chk({p, "_spi_addr"}, spi_address, 0);
        chk({p, "_spi_cpol"}, spi_cpol, 0);
        chk({p, "_spi_cpha"}, spi_cpha, 0);
        chk({p, "_rsp_valid"}, rsp_valid, 0);
        chk({p, "_rsp_data"}, rsp_data, 0);
        chk({p, "_rsp_addr"}, rsp_addr, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_fifo_count"}, fifo_count, 0);
        chk({p, "_req_ready"}, req_ready, 1);
    endtask

    // Reference model: in-order request log, frame length from the mode, slave reply from slave_f.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                starts = 0; have_cur = 1'b0; prev_start = 1'b0; prev_rsp = 1'b0; slv_active = 1'b0;
            end else begin
                if (spi_start) begin
                    cur = req_log[starts % 256];
                    chk("start_single_cycle", prev_start, 0);
                    chk("load_with_start", spi_load, 1);
                    chk("start_under_backpressure", rsp_valid, 0);
                    chk("start_has_request", pushes > starts, 1);
                    chk("tx_data", spi_data_in_master, cur.data);
                    chk("tx_addr", spi_address, cur.addr);
                    chk("tx_cpol", spi_cpol, cur.cpol);
                    chk("tx_cpha", spi_cpha, cur.cpha);
                    start_cyc = cyc;
                    start_log[starts % 256] = cyc;
                    starts++;
                    have_cur = 1'b1;
                    slv_cnt = 0;
                    slv_frame = 2 * BITS + int'(spi_cpol);
                    slv_val = slave_f(spi_data_in_master, spi_address);
                    slv_active = 1'b1;
                    spi_data_out_master = 8'($urandom);
                end else begin
                    chk("load_without_start", spi_load, 0);
                    if (have_cur) begin
                        chk("hold_data", spi_data_in_master, cur.data);
                        chk("hold_addr", spi_address, cur.addr);
                        chk("hold_cpol", spi_cpol, cur.cpol);
                        chk("hold_cpha", spi_cpha, cur.cpha);
                    end
                    if (slv_active) begin
                        slv_cnt++;
                        if (slv_cnt == slv_frame) begin
                            spi_data_out_master = slv_val;
                        end else begin
                            spi_data_out_master = 8'($urandom);
                            if (slv_cnt > slv_frame) slv_active = 1'b0;
                        end
                    end
                end
                if (rsp_valid && !prev_rsp) begin
                    last_lat = cyc - start_cyc;
                    last_rsp_data = rsp_data;
                    last_rsp_addr = rsp_addr;
                    rsp_seen++;
                    chk("rsp_has_frame", have_cur, 1);
                    chk("rsp_latency", last_lat, 2 * BITS + int'(cur.cpol) + 1);
                    chk("rsp_data", rsp_data, slave_f(cur.data, cur.addr));
                    chk("rsp_addr", rsp_addr, cur.addr);
                end
                chk("fifo_count", fifo_count, pushes - starts);
                chk("req_ready", req_ready, (pushes - starts) != DEPTH);
                prev_start = spi_start;
                prev_rsp = rsp_valid;
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] a, input logic c, input logic h);
        int guard = 0;
        @(negedge clk);
        req_data = d; req_addr = a; req_cpol = c; req_cpha = h; req_valid = 1'b1;
        while (!req_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", req_ready, 1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_log[pushes % 256] = '{d, a, c, h};
            pushes++;
            acc_cyc = cyc;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int n, input string name);
        int g = 0;
        while (rsp_seen < n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk(name, rsp_seen >= n, 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || fifo_count != 0 || rsp_valid) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs [5];
        int   base;
        int   sbase;
        int   hcyc;
        int   g;

        vecs[0] = '{8'h36, 2'd0, 1'b0, 1'b0, 8'h4B, 17};
        vecs[1] = '{8'hA5, 2'd2, 1'b1, 1'b0, 8'hDA, 18};
        vecs[2] = '{8'hFF, 2'd1, 1'b0, 1'b1, 8'h83, 17};
        vecs[3] = '{8'h00, 2'd3, 1'b1, 1'b1, 8'h7E, 18};
        vecs[4] = '{8'h5A, 2'd1, 1'b1, 1'b0, 8'h26, 18};

        fork
            monitor();
        join_none

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames, one at a time, from the vector table.
        for (int i = 0; i < 5; i++) begin
            base = rsp_seen;
            send(vecs[i].data, vecs[i].addr, vecs[i].cpol, vecs[i].cpha);
            wait_rsp(base + 1, "vec_rsp_timeout");
            chk("vec_start_delay", start_cyc - acc_cyc, 1);
            chk("vec_rsp_data", last_rsp_data, vecs[i].exp_rsp);
            chk("vec_rsp_addr", last_rsp_addr, vecs[i].addr);
            chk("vec_latency", last_lat, vecs[i].exp_lat);
            wait_idle();
        end

        // One active frame plus five queued requests; FIFO fills at four.
        base = rsp_seen;
        sbase = starts;
        send(8'($urandom), 2'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            send(8'($urandom), 2'($urandom), 1'b0, 1'b0);
            if (k == 3) begin
                @(negedge clk);
                chk("full_count", fifo_count, 4);
                chk("full_ready", req_ready, 0);
            end
        end
        wait_rsp(base + 6, "b2b_rsp_timeout");
        for (int j = 0; j < 5; j++) begin
            chk("b2b_spacing", start_log[(sbase + j + 1) % 256] - start_log[(sbase + j) % 256], PERIOD);
        end
        wait_idle();

        // Response backpressure holds off the next frame.
        base = rsp_seen;
        sbase = starts;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(8'($urandom), 2'($urandom), 1'b0, 1'b0);
        wait_rsp(base + 1, "bp_first_rsp_timeout");
        repeat (50) @(negedge clk);
        chk("bp_no_start", starts, sbase + 1);
        chk("bp_rsp_held", rsp_valid, 1);
        chk("bp_queue", fifo_count, 2);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        hcyc = cyc;
        g = 0;
        while (starts < sbase + 2 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("bp_restart_seen", starts, sbase + 2);
        chk("bp_restart_delay", start_log[(sbase + 1) % 256] - hcyc, 1);
        wait_rsp(base + 3, "bp_rsp_timeout");
        wait_idle();

        // Random traffic with random response backpressure.
        base = rsp_seen;
        done_r = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
                end
                done_r = 1'b1;
            end
            begin
                while (!done_r) begin
                    @(negedge clk);
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_rsp(base + 40, "rand_rsp_timeout");
        wait_idle();
        chk("rand_all_rsp", rsp_seen - base, 40);
`ifdef SPI_SCHED_STATS_EN
        chk("xfer_count", xfer_count, rsp_seen);
`endif

        // Reset in the middle of SHIFT with three requests queued.
        for (int k = 0; k < 4; k++) send(8'($urandom), 2'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_queue", fifo_count, 3);
        base = rsp_seen;
        #2;
        reset = 1'b1;
        pushes = 0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("rst_no_rsp", rsp_seen, base);
        chk("rst_no_start", starts, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_req_ready", req_ready, 1);
`ifdef SPI_SCHED_STATS_EN
        chk("rst_xfer_count", xfer_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
